// File: rtl/jtframe_mc2_pkg.sv
// Shared constants and types for the MC2 frame: joystick bit map,
// default reset stretch length and the synchronised control vector.
package jtframe_mc2_pkg;

  localparam int unsigned RIGHT      = 32'd0;
  localparam int unsigned LEFT       = 32'd1;
  localparam int unsigned DOWN       = 32'd2;
  localparam int unsigned UP         = 32'd3;
  localparam int unsigned B1         = 32'd4;
  localparam int unsigned B2         = 32'd5;
  localparam int unsigned RSTLEN_DEF = 32'd1024;

  // One DB9 port, active-low as seen on the pins
  typedef struct packed {
    logic p9;
    logic p6;
    logic up;
    logic down;
    logic left;
    logic right;
  } db9_t;

  // Everything that crosses the synchroniser, all active-low
  typedef struct packed {
    logic [1:0] start_n;
    logic [1:0] coin_n;
    db9_t       joy2;
    db9_t       joy1;
  } ctrl_t;

  function automatic logic [9:0] joy_map(input db9_t p, input logic b2_en);
    logic [9:0] j;
    j        = 10'h3FF;
    j[RIGHT] = p.right;
    j[LEFT]  = p.left;
    j[DOWN]  = p.down;
    j[UP]    = p.up;
    j[B1]    = p.p6;
    if (b2_en) begin
      j[B2] = p.p9;
    end else begin
      j[B2] = 1'b1;
    end
    return j;
  endfunction

endpackage

// File: rtl/jtframe_mc2_if.sv
// Game-facing bus of the MC2 frame: active-low controls and decoded OSD settings.
interface jtframe_mc2_if;
  logic [9:0] game_joystick1;
  logic [9:0] game_joystick2;
  logic [9:0] game_joystick3;
  logic [9:0] game_joystick4;
  logic [3:0] game_coin;
  logic [3:0] game_start;
  logic       enable_fm;
  logic       enable_psg;
  logic       dip_test;
  logic       dip_pause;
  logic       dip_flip;
  logic [1:0] dip_fxlevel;

  modport master (
    output game_joystick1, game_joystick2, game_joystick3, game_joystick4,
    output game_coin, game_start,
    output enable_fm, enable_psg, dip_test, dip_pause, dip_flip, dip_fxlevel
  );

  modport slave (
    input game_joystick1, game_joystick2, game_joystick3, game_joystick4,
    input game_coin, game_start,
    input enable_fm, enable_psg, dip_test, dip_pause, dip_flip, dip_fxlevel
  );
endinterface

// File: rtl/jtframe_mc2_dac.sv
// One first-order sigma-delta channel: the carry out of a 16-bit
// accumulator is the 1-bit output stream.
module jtframe_mc2_dac #(
  parameter bit SIGNED_SND = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] snd,
  output logic        dac
);
  logic [15:0] u_s;
  logic [16:0] acc_d;
  logic [16:0] acc_q;

  // Offset-binary conversion and accumulate; bit 16 only holds the last carry
  always_comb begin
    u_s = snd;
    if (SIGNED_SND) begin
      u_s = {~snd[15], snd[14:0]};
    end else begin
      u_s = snd;
    end
    acc_d = {1'b0, acc_q[15:0]} + {1'b0, u_s};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= 17'd0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign dac = acc_q[16];
endmodule

// File: rtl/jtframe_mc2_frame.sv
// MC2 board glue: synchronised DB9/keyboard inputs, OSD decode,
// stretched game reset and two sigma-delta audio channels.
module jtframe_mc2_frame
  import jtframe_mc2_pkg::*;
#(
  parameter bit          SIGNED_SND = 1'b1,
  parameter int unsigned BUTTONS    = 32'd2,
  parameter int unsigned RSTLEN     = RSTLEN_DEF
) (
  input  logic          clk_sys,
  input  logic          rst,
  input  logic          pll_locked,
  input  logic          rst_req,
  input  logic          downloading,
  input  logic [31:0]   status,
  input  logic          joy1_up_i,
  input  logic          joy1_down_i,
  input  logic          joy1_left_i,
  input  logic          joy1_right_i,
  input  logic          joy1_p6_i,
  input  logic          joy1_p9_i,
  input  logic          joy2_up_i,
  input  logic          joy2_down_i,
  input  logic          joy2_left_i,
  input  logic          joy2_right_i,
  input  logic          joy2_p6_i,
  input  logic          joy2_p9_i,
  input  logic [1:0]    key_coin,
  input  logic [1:0]    key_start,
  input  logic [15:0]   snd_left,
  input  logic [15:0]   snd_right,
  output logic          game_rst,
  output logic          joy1_p7_o,
  output logic          joy2_p7_o,
  jtframe_mc2_if.master gio,
  output logic          AUDIO_L,
  output logic          AUDIO_R
);
  localparam int unsigned CW = $clog2(RSTLEN + 32'd1);

  ctrl_t          raw_s, sync1_q, sync2_q;
  logic [9:0]     joy1_d, joy1_q, joy2_d, joy2_q;
  logic [3:0]     coin_d, coin_q, start_d, start_q;
  logic           fm_d, fm_q, psg_d, psg_q, test_d, test_q;
  logic           pause_d, pause_q, flip_d, flip_q;
  logic [1:0]     fx_d, fx_q;
  logic [CW-1:0]  cnt_d, cnt_q;
  logic           grst_d, grst_q, src_s;
  logic           unused_s;

  assign unused_s = ^{status[31:12], status[5:2], status[0]};

  // Keys are inverted before synchronising so the preset value means "idle"
  always_comb begin
    raw_s.joy1    = '{p9: joy1_p9_i, p6: joy1_p6_i, up: joy1_up_i,
                      down: joy1_down_i, left: joy1_left_i, right: joy1_right_i};
    raw_s.joy2    = '{p9: joy2_p9_i, p6: joy2_p6_i, up: joy2_up_i,
                      down: joy2_down_i, left: joy2_left_i, right: joy2_right_i};
    raw_s.coin_n  = ~key_coin;
    raw_s.start_n = ~key_start;
  end

  always_comb begin
    joy1_d  = joy_map(sync2_q.joy1, BUTTONS > 32'd1);
    joy2_d  = joy_map(sync2_q.joy2, BUTTONS > 32'd1);
    coin_d  = {2'b11, sync2_q.coin_n};
    start_d = {2'b11, sync2_q.start_n};
    flip_d  = status[1];
    fx_d    = status[7:6];
    psg_d   = ~status[8];
    fm_d    = ~status[9];
    test_d  = ~status[10];
    pause_d = ~status[11];
  end

  // Reset stretch: any source restarts the count from zero
  always_comb begin
    src_s  = rst | ~pll_locked | rst_req | downloading;
    cnt_d  = cnt_q;
    grst_d = 1'b1;
    if (src_s) begin
      cnt_d = {CW{1'b0}};
    end else if (cnt_q != CW'(RSTLEN)) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      grst_d = 1'b0;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      sync1_q <= '1;
      sync2_q <= '1;
      joy1_q  <= 10'h3FF;
      joy2_q  <= 10'h3FF;
      coin_q  <= 4'hF;
      start_q <= 4'hF;
      fm_q    <= 1'b1;
      psg_q   <= 1'b1;
      test_q  <= 1'b1;
      pause_q <= 1'b1;
      flip_q  <= 1'b0;
      fx_q    <= 2'd0;
      cnt_q   <= {CW{1'b0}};
      grst_q  <= 1'b1;
    end else begin
      sync1_q <= raw_s;
      sync2_q <= sync1_q;
      joy1_q  <= joy1_d;
      joy2_q  <= joy2_d;
      coin_q  <= coin_d;
      start_q <= start_d;
      fm_q    <= fm_d;
      psg_q   <= psg_d;
      test_q  <= test_d;
      pause_q <= pause_d;
      flip_q  <= flip_d;
      fx_q    <= fx_d;
      cnt_q   <= cnt_d;
      grst_q  <= grst_d;
    end
  end

  assign game_rst            = grst_q;
  assign joy1_p7_o           = 1'b1;
  assign joy2_p7_o           = 1'b1;
  assign gio.game_joystick1  = joy1_q;
  assign gio.game_joystick2  = joy2_q;
  assign gio.game_joystick3  = 10'h3FF;
  assign gio.game_joystick4  = 10'h3FF;
  assign gio.game_coin       = coin_q;
  assign gio.game_start      = start_q;
  assign gio.enable_fm       = fm_q;
  assign gio.enable_psg      = psg_q;
  assign gio.dip_test        = test_q;
  assign gio.dip_pause       = pause_q;
  assign gio.dip_flip        = flip_q;
  assign gio.dip_fxlevel     = fx_q;

  jtframe_mc2_dac #(.SIGNED_SND(SIGNED_SND)) u_dac_l (
    .clk (clk_sys),
    .rst (rst),
    .snd (snd_left),
    .dac (AUDIO_L)
  );

  jtframe_mc2_dac #(.SIGNED_SND(SIGNED_SND)) u_dac_r (
    .clk (clk_sys),
    .rst (rst),
    .snd (snd_right),
    .dac (AUDIO_R)
  );
endmodule

// File: tb/tb_jtframe_mc2_frame.sv
// Directed plus randomised bench for two frame variants (signed/2 buttons and
// offset-binary/1 button), checked against a cycle-level behavioural model.
module tb_jtframe_mc2_frame;
  localparam int RSTLEN = 1024;

  logic clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  logic        rst, pll_locked, rst_req, downloading;
  logic [31:0] status;
  logic        j1u, j1d, j1l, j1r, j1p6, j1p9;
  logic        j2u, j2d, j2l, j2r, j2p6, j2p9;
  logic [1:0]  key_coin, key_start;
  logic [15:0] snd_left, snd_right;
  logic        grst [2];
  logic        p7a [2];
  logic        p7b [2];
  logic        aul [2];
  logic        aur [2];

  jtframe_mc2_if gif0();
  jtframe_mc2_if gif1();

  jtframe_mc2_frame #(.SIGNED_SND(1'b1), .BUTTONS(2), .RSTLEN(RSTLEN)) dut0 (
    .clk_sys(clk_sys), .rst(rst), .pll_locked(pll_locked), .rst_req(rst_req),
    .downloading(downloading), .status(status),
    .joy1_up_i(j1u), .joy1_down_i(j1d), .joy1_left_i(j1l), .joy1_right_i(j1r),
    .joy1_p6_i(j1p6), .joy1_p9_i(j1p9),
    .joy2_up_i(j2u), .joy2_down_i(j2d), .joy2_left_i(j2l), .joy2_right_i(j2r),
    .joy2_p6_i(j2p6), .joy2_p9_i(j2p9),
    .key_coin(key_coin), .key_start(key_start), .snd_left(snd_left), .snd_right(snd_right),
    .game_rst(grst[0]), .joy1_p7_o(p7a[0]), .joy2_p7_o(p7b[0]), .gio(gif0.master),
    .AUDIO_L(aul[0]), .AUDIO_R(aur[0])
  );

  jtframe_mc2_frame #(.SIGNED_SND(1'b0), .BUTTONS(1), .RSTLEN(RSTLEN)) dut1 (
    .clk_sys(clk_sys), .rst(rst), .pll_locked(pll_locked), .rst_req(rst_req),
    .downloading(downloading), .status(status),
    .joy1_up_i(j1u), .joy1_down_i(j1d), .joy1_left_i(j1l), .joy1_right_i(j1r),
    .joy1_p6_i(j1p6), .joy1_p9_i(j1p9),
    .joy2_up_i(j2u), .joy2_down_i(j2d), .joy2_left_i(j2l), .joy2_right_i(j2r),
    .joy2_p6_i(j2p6), .joy2_p9_i(j2p9),
    .key_coin(key_coin), .key_start(key_start), .snd_left(snd_left), .snd_right(snd_right),
    .game_rst(grst[1]), .joy1_p7_o(p7a[1]), .joy2_p7_o(p7b[1]), .gio(gif1.master),
    .AUDIO_L(aul[1]), .AUDIO_R(aur[1])
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  logic [15:0] hist[$];
  int          hold_left;
  logic        exp_grst;
  logic [6:0]  exp_dips;
  longint      acc_l [2];
  longint      acc_r [2];
  logic        exp_al [2];
  logic        exp_ar [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Active-low snapshot: joy1 in bits 5:0 (right,left,down,up,p6,p9), joy2 in 11:6, coin 13:12, start 15:14
  function automatic logic [15:0] cur_vec();
    return {~key_start, ~key_coin, j2p9, j2p6, j2u, j2d, j2l, j2r,
            j1p9, j1p6, j1u, j1d, j1l, j1r};
  endfunction

  function automatic logic [9:0] exp_joy(input logic [5:0] v, input bit two_buttons);
    return {4'hF, (two_buttons ? v[5] : 1'b1), v[4:0]};
  endfunction

  task automatic dac_step(input int d, input logic [15:0] s, inout longint acc, output logic o);
    longint u, sum;
    u = (d == 0) ? longint'(s ^ 16'h8000) : longint'(s);
    if (rst) begin
      acc = 0;
      o   = 1'b0;
    end else begin
      sum = (acc % 65536) + u;
      o   = (sum >= 65536);
      acc = sum;
    end
  endtask

  task automatic model_edge();
    if (rst) begin
      hist = {16'hFFFF, 16'hFFFF, 16'hFFFF};
    end else begin
      hist.push_back(cur_vec());
      while (hist.size() > 3) void'(hist.pop_front());
    end
    if (rst || !pll_locked || rst_req || downloading) begin
      hold_left = RSTLEN;
      exp_grst  = 1'b1;
    end else if (hold_left > 0) begin
      hold_left--;
      exp_grst = 1'b1;
    end else begin
      exp_grst = 1'b0;
    end
    if (rst) exp_dips = 7'b1111_0_00;
    else exp_dips = {~status[9], ~status[8], ~status[10], ~status[11], status[1], status[7:6]};
    for (int d = 0; d < 2; d++) begin
      dac_step(d, snd_left,  acc_l[d], exp_al[d]);
      dac_step(d, snd_right, acc_r[d], exp_ar[d]);
    end
  endtask

  task automatic cyc();
    @(posedge clk_sys);
    model_edge();
    @(negedge clk_sys);
  endtask

  task automatic chk_dut(input int d, input logic [9:0] j1, input logic [9:0] j2,
                         input logic [9:0] j3, input logic [9:0] j4, input logic [3:0] c,
                         input logic [3:0] s, input logic [6:0] dips, input logic gr,
                         input logic al, input logic ar);
    logic [15:0] v;
    string sfx;
    v   = hist[0];
    sfx = (d == 0) ? "0" : "1";
    chk({"joy1_", sfx}, 32'(j1), 32'(exp_joy(v[5:0], d == 0)));
    chk({"joy2_", sfx}, 32'(j2), 32'(exp_joy(v[11:6], d == 0)));
    chk({"joy34_", sfx}, {j3, j4}, {10'h3FF, 10'h3FF});
    chk({"coin_", sfx}, 32'(c), {28'd0, 2'b11, v[13:12]});
    chk({"start_", sfx}, 32'(s), {28'd0, 2'b11, v[15:14]});
    chk({"dips_", sfx}, 32'(dips), 32'(exp_dips));
    chk({"game_rst_", sfx}, 32'(gr), 32'(exp_grst));
    chk({"audio_", sfx}, {al, ar}, {exp_al[d], exp_ar[d]});
  endtask

  task automatic check_all();
    chk_dut(0, gif0.game_joystick1, gif0.game_joystick2, gif0.game_joystick3, gif0.game_joystick4,
            gif0.game_coin, gif0.game_start,
            {gif0.enable_fm, gif0.enable_psg, gif0.dip_test, gif0.dip_pause, gif0.dip_flip, gif0.dip_fxlevel},
            grst[0], aul[0], aur[0]);
    chk_dut(1, gif1.game_joystick1, gif1.game_joystick2, gif1.game_joystick3, gif1.game_joystick4,
            gif1.game_coin, gif1.game_start,
            {gif1.enable_fm, gif1.enable_psg, gif1.dip_test, gif1.dip_pause, gif1.dip_flip, gif1.dip_fxlevel},
            grst[1], aul[1], aur[1]);
  endtask

  // Count cycles until dut0 drops game_rst (bounded)
  task automatic measure_hold(output int n);
    n = 0;
    while (grst[0] === 1'b1 && n < 3000) begin
      cyc();
      n++;
    end
  endtask

  initial begin
    int n, first, zeros;
    rst = 1'b1; pll_locked = 1'b1; rst_req = 1'b0; downloading = 1'b0;
    status = 32'd0; key_coin = 2'b00; key_start = 2'b00;
    snd_left = 16'h0000; snd_right = 16'h0000;
    {j1u, j1d, j1l, j1r, j1p6, j1p9} = 6'h3F;
    {j2u, j2d, j2l, j2r, j2p6, j2p9} = 6'h3F;
    hold_left = 0; exp_grst = 1'b1; exp_dips = 7'b1111_0_00;

    repeat (5) cyc();
    check_all();
    chk("p7", {p7a[0], p7b[0], p7a[1], p7b[1]}, 32'hF);

    // Release reset: game_rst held for RSTLEN cycles; signed zero gives 0,1,0,1 on AUDIO_L
    rst = 1'b0;
    n = 0;
    while (grst[0] === 1'b1 && n < 3000) begin
      cyc();
      n++;
      if (n <= 8) chk("audio_alt", 32'(aul[0]), 32'(n % 2 == 0));
    end
    chk("hold_after_rst", n, RSTLEN + 1);
    check_all();

    // Downloading mid-hold restarts the counter
    pll_locked = 1'b0;
    cyc();
    pll_locked = 1'b1;
    repeat (500) cyc();
    chk("held_at_500", 32'(grst[0]), 32'd1);
    downloading = 1'b1;
    repeat (10) cyc();
    downloading = 1'b0;
    measure_hold(n);
    chk("hold_after_dl", n, RSTLEN + 1);
    check_all();

    // Joystick bit map and latency
    j1l = 1'b0; j2p9 = 1'b0;
    repeat (2) cyc();
    chk("joy_latency", {gif0.game_joystick1, gif0.game_joystick2}, {10'h3FF, 10'h3FF});
    cyc();
    chk("joy1_left", 32'(gif0.game_joystick1), 32'h3FD);
    chk("joy2_p9", 32'(gif0.game_joystick2), 32'h3DF);
    chk("joy2_p9_1btn", 32'(gif1.game_joystick2), 32'h3FF);
    check_all();
    j1l = 1'b1; j2p9 = 1'b1;

    // OSD decode
    status = 32'h0000_0EC2;
    cyc();
    chk("osd_decode", {gif0.dip_flip, gif0.dip_fxlevel, gif0.enable_psg, gif0.enable_fm,
                       gif0.dip_test, gif0.dip_pause}, 32'b1_11_1_0_0_0);
    check_all();

    // Coin pulse
    repeat (4) cyc();
    key_coin[0] = 1'b1;
    first = -1; zeros = 0;
    for (int k = 1; k <= 12; k++) begin
      cyc();
      if (k == 4) key_coin[0] = 1'b0;
      if (gif0.game_coin[0] === 1'b0) begin
        zeros++;
        if (first < 0) first = k;
      end
    end
    chk("coin_start", first, 3);
    chk("coin_width", zeros, 4);

    // Random traffic against the model
    for (int k = 0; k < 400; k++) begin
      {j1u, j1d, j1l, j1r, j1p6, j1p9} = 6'($urandom);
      {j2u, j2d, j2l, j2r, j2p6, j2p9} = 6'($urandom);
      key_coin    = 2'($urandom);
      key_start   = 2'($urandom);
      status      = $urandom;
      snd_left    = 16'($urandom);
      snd_right   = 16'($urandom);
      rst_req     = ($urandom_range(0, 99) == 0);
      downloading = ($urandom_range(0, 149) == 0);
      pll_locked  = ($urandom_range(0, 199) != 0);
      cyc();
      check_all();
    end
    rst_req = 1'b0; downloading = 1'b0; pll_locked = 1'b1;

    // Near full scale: exactly one zero per 65536 cycles
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    snd_left = 16'h7FFF;
    zeros = 0;
    for (int k = 0; k < 65536; k++) begin
      cyc();
      if (aul[0] === 1'b0) zeros++;
    end
    chk("density_7fff", zeros, 1);
    check_all();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
